// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and status signal bundle for reg_scoreboard.
// The pipeline (hazard unit side) is the master; the scoreboard is the slave.
interface reg_scoreboard_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_WB = 2
);
    localparam int unsigned NUM_REGS = 2**ADDR_W;

    logic                     issue_valid;
    logic                     issue_we;
    logic [ADDR_W-1:0]        issue_rd;
    logic [ADDR_W-1:0]        issue_rs1;
    logic [ADDR_W-1:0]        issue_rs2;
    logic                     issue_ready;
    logic                     hazard;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*ADDR_W-1:0] wb_rd;
    logic [NUM_REGS-1:0]      busy;
    logic [NUM_REGS-1:0]      wb_onehot;
    logic                     underflow;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_rs1, issue_rs2,
        output wb_valid, wb_rd,
        input  issue_ready, hazard, busy, wb_onehot, underflow
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_rs1, issue_rs2,
        input  wb_valid, wb_rd,
        output issue_ready, hazard, busy, wb_onehot, underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard producing RAW hazard / WAW stall and a registered wb one-hot.
// Define SCOREBOARD_BYPASS_EN to let same-cycle writebacks release hazards (write-before-read regfile).
module reg_scoreboard #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned NUM_WB         = 2,
    parameter int unsigned CNT_W          = 2,
    parameter bit          ZERO_HARDWIRED = 1'b1
) (
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);
    localparam int unsigned NUM_REGS = 2**ADDR_W;
    localparam int unsigned SUM_W    = CNT_W + 2;
    localparam int unsigned DEC_W    = $clog2(NUM_WB + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [DEC_W-1:0]    dec   [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] sat;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] wb_oh_d;
    logic [NUM_REGS-1:0] wb_oh_q;
    logic                uf_d;
    logic                uf_q;
    logic                hazard;
    logic                ready;
    logic                issue_fire;

    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (!(ZERO_HARDWIRED && r == '0)) begin
            v[r] = 1'b1;
        end
        return v;
    endfunction

    // Per-register writeback decrement and the one-hot of this cycle's writebacks.
    always_comb begin
        logic [ADDR_W-1:0] rd;
        wb_oh_d = '0;
        rd      = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            dec[i] = '0;
        end
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            rd = sb.wb_rd[k*ADDR_W +: ADDR_W];
            if (sb.wb_valid[k]) begin
                wb_oh_d = wb_oh_d | decode(rd);
                dec[rd] = dec[rd] + DEC_W'(1);
            end
        end
    end

    // Pending/saturated views seen by the issue logic.
    always_comb begin
        pend = '0;
        sat  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (!(ZERO_HARDWIRED && i == 0)) begin
`ifdef SCOREBOARD_BYPASS_EN
                pend[i] = SUM_W'(cnt_q[i]) > SUM_W'(dec[i]);
                sat[i]  = (cnt_q[i] == CNT_MAX) && (dec[i] == '0);
`else
                pend[i] = cnt_q[i] != '0;
                sat[i]  = cnt_q[i] == CNT_MAX;
`endif
            end
        end
    end

    assign hazard     = pend[sb.issue_rs1] | pend[sb.issue_rs2];
    assign ready      = sb.issue_valid & ~hazard & ~(sb.issue_we & sat[sb.issue_rd]);
    assign issue_fire = ready & sb.issue_we;

    // Count update evaluated wide so that over-decrement is visible as a negative result.
    always_comb begin
        logic [SUM_W-1:0] sum;
        uf_d   = 1'b0;
        sum    = '0;
        busy_d = '0;
        inc    = issue_fire ? decode(sb.issue_rd) : '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            sum = SUM_W'(cnt_q[i]) + SUM_W'(inc[i]) - SUM_W'(dec[i]);
            if (ZERO_HARDWIRED && i == 0) begin
                cnt_d[i] = '0;
            end else if (sum[SUM_W-1]) begin
                cnt_d[i] = '0;
                uf_d     = 1'b1;
            end else if (sum > SUM_W'(CNT_MAX)) begin
                cnt_d[i] = CNT_MAX;
            end else begin
                cnt_d[i] = sum[CNT_W-1:0];
            end
            busy_d[i] = cnt_d[i] != '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            busy_q  <= '0;
            wb_oh_q <= '0;
            uf_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_q  <= busy_d;
            wb_oh_q <= wb_oh_d;
            uf_q    <= uf_d;
        end
    end

    assign sb.hazard      = hazard;
    assign sb.issue_ready = ready;
    assign sb.busy        = busy_q;
    assign sb.wb_onehot   = wb_oh_q;
    assign sb.underflow   = uf_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized traffic against a count model.
`timescale 1ns/1ps
module tb_reg_scoreboard;
    localparam int ADDR_W   = 5;
    localparam int NUM_WB   = 2;
    localparam int CNT_W    = 2;
    localparam int NUM_REGS = 32;
    localparam int MAXC     = 3;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.ADDR_W(ADDR_W), .NUM_WB(NUM_WB)) sbi ();

    reg_scoreboard #(
        .ADDR_W(ADDR_W), .NUM_WB(NUM_WB), .CNT_W(CNT_W), .ZERO_HARDWIRED(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .sb(sbi.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: plain integer pending counts plus expected registered outputs.
    int                  cnt [NUM_REGS];
    logic [NUM_REGS-1:0] exp_busy;
    logic [NUM_REGS-1:0] exp_oh;
    logic                exp_uf;

    function automatic int wb_hits(int r);
        int n = 0;
        for (int k = 0; k < NUM_WB; k++)
            if (sbi.wb_valid[k] && int'(sbi.wb_rd[k*ADDR_W +: ADDR_W]) == r) n++;
        return n;
    endfunction

    function automatic int visible(int r);
        int v = cnt[r];
        if (BYPASS) v = v - wb_hits(r);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic logic m_hazard();
        return visible(int'(sbi.issue_rs1)) > 0 || visible(int'(sbi.issue_rs2)) > 0;
    endfunction

    function automatic logic m_ready();
        return sbi.issue_valid && !m_hazard() &&
               !(sbi.issue_we && visible(int'(sbi.issue_rd)) >= MAXC);
    endfunction

    // Advance one clock: model the edge from current inputs, end at the following negedge.
    task automatic tick();
        int  n;
        int  nc [NUM_REGS];
        bit  fire;
        logic [NUM_REGS-1:0] oh;
        logic uf;
        fire = m_ready() && sbi.issue_we;
        oh = '0;
        uf = 1'b0;
        for (int k = 0; k < NUM_WB; k++)
            if (sbi.wb_valid[k] && sbi.wb_rd[k*ADDR_W +: ADDR_W] != 0)
                oh[sbi.wb_rd[k*ADDR_W +: ADDR_W]] = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            n = cnt[r] + ((fire && int'(sbi.issue_rd) == r) ? 1 : 0) - wb_hits(r);
            if (r == 0) n = 0;
            if (n < 0) begin
                n  = 0;
                uf = 1'b1;
            end
            nc[r] = n;
        end
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) nc[r] = 0;
            oh = '0;
            uf = 1'b0;
        end
        @(posedge clk);
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r]      = nc[r];
            exp_busy[r] = nc[r] != 0;
        end
        exp_oh = oh;
        exp_uf = uf;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] wbv, input logic [4:0] w0, input logic [4:0] w1);
        sbi.issue_valid = v;
        sbi.issue_we    = we;
        sbi.issue_rd    = rd;
        sbi.issue_rs1   = rs1;
        sbi.issue_rs2   = rs2;
        sbi.wb_valid    = wbv;
        sbi.wb_rd       = {w1, w0};
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 1, 5'd12, 0, 0, 2'b11, 5'd3, 5'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (sbi.busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", sbi.busy); end
        n_tests++; if (sbi.wb_onehot !== '0) begin n_fail++; $display("FAIL reset_onehot: got %h want 0", sbi.wb_onehot); end
        n_tests++; if (sbi.underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", sbi.underflow); end
        drive(1, 1, 5'd12, 5'd12, 5'd31, 2'b00, 0, 0);
        n_tests++; if (sbi.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", sbi.issue_ready); end
        n_tests++; if (sbi.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", sbi.hazard); end
    endtask

    task automatic test_raw();
        do_reset();
        drive(1, 1, 5'd5, 0, 0, 2'b00, 0, 0);
        n_tests++; if (sbi.issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_issue_ready: got %b want 1", sbi.issue_ready); end
        tick();
        n_tests++; if (sbi.busy[5] !== 1'b1) begin n_fail++; $display("FAIL raw_busy5: got %b want 1", sbi.busy[5]); end
        drive(1, 0, 0, 5'd5, 0, 2'b00, 0, 0);
        n_tests++; if (sbi.hazard !== 1'b1) begin n_fail++; $display("FAIL raw_hazard_c1: got %b want 1", sbi.hazard); end
        n_tests++; if (sbi.issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_ready_c1: got %b want 0", sbi.issue_ready); end
        tick();
        drive(1, 0, 0, 5'd5, 0, 2'b01, 5'd5, 0);
        n_tests++; if (sbi.hazard !== !BYPASS) begin n_fail++; $display("FAIL raw_hazard_c2: got %b want %b", sbi.hazard, !BYPASS); end
        tick();
        n_tests++; if (sbi.wb_onehot !== 32'h20) begin n_fail++; $display("FAIL raw_onehot: got %h want 00000020", sbi.wb_onehot); end
        n_tests++; if (sbi.busy[5] !== 1'b0) begin n_fail++; $display("FAIL raw_busy5_clear: got %b want 0", sbi.busy[5]); end
        drive(1, 0, 0, 5'd5, 0, 2'b00, 0, 0);
        n_tests++; if (sbi.hazard !== 1'b0) begin n_fail++; $display("FAIL raw_hazard_c3: got %b want 0", sbi.hazard); end
        tick();
    endtask

    task automatic test_zero();
        do_reset();
        drive(1, 1, 5'd0, 0, 0, 2'b00, 0, 0);
        n_tests++; if (sbi.issue_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", sbi.issue_ready); end
        tick();
        n_tests++; if (sbi.busy !== '0) begin n_fail++; $display("FAIL zero_busy: got %h want 0", sbi.busy); end
        drive(1, 1, 5'd0, 5'd0, 5'd0, 2'b11, 5'd0, 5'd0);
        n_tests++; if (sbi.hazard !== 1'b0) begin n_fail++; $display("FAIL zero_hazard: got %b want 0", sbi.hazard); end
        tick();
        n_tests++; if (sbi.underflow !== 1'b0) begin n_fail++; $display("FAIL zero_underflow: got %b want 0", sbi.underflow); end
        n_tests++; if (sbi.wb_onehot !== '0) begin n_fail++; $display("FAIL zero_onehot: got %h want 0", sbi.wb_onehot); end
        n_tests++; if (sbi.busy !== '0) begin n_fail++; $display("FAIL zero_busy2: got %h want 0", sbi.busy); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'd7, 0, 0, 2'b00, 0, 0);
            n_tests++; if (sbi.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_fill%0d: got %b want 1", i, sbi.issue_ready); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5'd7, 0, 0, 2'b00, 0, 0);
            n_tests++; if (sbi.issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_stall%0d: got %b want 0", i, sbi.issue_ready); end
            tick();
        end
        drive(1, 1, 5'd7, 0, 0, 2'b01, 5'd7, 0);
        n_tests++; if (sbi.issue_ready !== BYPASS) begin n_fail++; $display("FAIL sat_wb_cycle: got %b want %b", sbi.issue_ready, BYPASS); end
        sbi.issue_valid = 1'b0;
        tick();
        drive(1, 1, 5'd7, 0, 0, 2'b00, 0, 0);
        n_tests++; if (sbi.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_release: got %b want 1", sbi.issue_ready); end
        tick();
        n_tests++; if (sbi.busy[7] !== 1'b1) begin n_fail++; $display("FAIL sat_busy7: got %b want 1", sbi.busy[7]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 1, 5'd9, 0, 0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 5'd9, 0, 0, 2'b10, 0, 5'd9);
        n_tests++; if (sbi.issue_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", sbi.issue_ready); end
        tick();
        n_tests++; if (sbi.busy[9] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy9: got %b want 1", sbi.busy[9]); end
        n_tests++; if (sbi.wb_onehot !== 32'h200) begin n_fail++; $display("FAIL b2b_onehot: got %h want 00000200", sbi.wb_onehot); end
        drive(0, 0, 0, 0, 0, 2'b01, 5'd9, 0);
        tick();
        n_tests++; if (sbi.busy[9] !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", sbi.busy[9]); end
        n_tests++; if (sbi.underflow !== 1'b0) begin n_fail++; $display("FAIL b2b_underflow: got %b want 0", sbi.underflow); end
    endtask

    task automatic test_double_wb();
        do_reset();
        drive(1, 1, 5'd3, 0, 0, 2'b00, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 2'b11, 5'd3, 5'd3);
        tick();
        n_tests++; if (sbi.busy[3] !== 1'b0) begin n_fail++; $display("FAIL dwb_busy3: got %b want 0", sbi.busy[3]); end
        n_tests++; if (sbi.underflow !== 1'b1) begin n_fail++; $display("FAIL dwb_underflow: got %b want 1", sbi.underflow); end
        n_tests++; if (sbi.wb_onehot !== 32'h8) begin n_fail++; $display("FAIL dwb_onehot: got %h want 00000008", sbi.wb_onehot); end
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
        tick();
        n_tests++; if (sbi.underflow !== 1'b0) begin n_fail++; $display("FAIL dwb_pulse_end: got %b want 0", sbi.underflow); end
        drive(1, 1, 5'd2, 0, 0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 5'd4, 0, 0, 2'b00, 0, 0);
        tick();
        n_tests++; if (sbi.busy !== 32'h14) begin n_fail++; $display("FAIL dwb_busy24: got %h want 00000014", sbi.busy); end
        drive(1, 1, 5'd6, 0, 0, 2'b01, 5'd2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (sbi.busy !== '0) begin n_fail++; $display("FAIL dwb_rst_busy: got %h want 0", sbi.busy); end
        n_tests++; if (sbi.wb_onehot !== '0) begin n_fail++; $display("FAIL dwb_rst_onehot: got %h want 0", sbi.wb_onehot); end
        drive(0, 0, 0, 0, 0, 2'b01, 5'd2, 0);
        tick();
        n_tests++; if (sbi.underflow !== 1'b1) begin n_fail++; $display("FAIL dwb_rst_discard: got %b want 1", sbi.underflow); end
    endtask

    task automatic test_random();
        logic exp_h;
        logic exp_r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                  2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 79) == 0);
            exp_h = m_hazard();
            exp_r = m_ready();
            n_tests++; if (sbi.hazard !== exp_h) begin n_fail++; $display("FAIL rnd_hazard c%0d: got %b want %b", c, sbi.hazard, exp_h); end
            n_tests++; if (sbi.issue_ready !== exp_r) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, sbi.issue_ready, exp_r); end
            tick();
            rst = 1'b0;
            n_tests++; if (sbi.busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h want %h", c, sbi.busy, exp_busy); end
            n_tests++; if (sbi.wb_onehot !== exp_oh) begin n_fail++; $display("FAIL rnd_onehot c%0d: got %h want %h", c, sbi.wb_onehot, exp_oh); end
            n_tests++; if (sbi.underflow !== exp_uf) begin n_fail++; $display("FAIL rnd_underflow c%0d: got %b want %b", c, sbi.underflow, exp_uf); end
        end
    endtask

    initial begin
        for (int r = 0; r < NUM_REGS; r++) cnt[r] = 0;
        exp_busy = '0;
        exp_oh   = '0;
        exp_uf   = 1'b0;
        rst = 1'b1;
        sbi.issue_valid = 1'b0;
        sbi.issue_we    = 1'b0;
        sbi.issue_rd    = '0;
        sbi.issue_rs1   = '0;
        sbi.issue_rs2   = '0;
        sbi.wb_valid    = '0;
        sbi.wb_rd       = '0;
        @(negedge clk);
        test_reset();
        test_raw();
        test_zero();
        test_saturate();
        test_back_to_back();
        test_double_wb();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register-write scoreboard for the 5-stage RISC-V pipeline. It decodes destination-register numbers into one-hot vectors, as a write-enable decoder does, and also keeps a per-register pending-write count. The count is incremented at issue (ID stage) and decremented at writeback (WB stage, one or more ports). The block sits beside the hazard unit and produces the read-after-write (RAW) hazard and write-after-write (WAW) stall signals, plus a registered write one-hot vector for the register file.

## Interface
- ADDR_W, 5, register-number width; NUM_REGS = 2**ADDR_W
- NUM_WB, 2, number of writeback ports
- CNT_W, 2, width of each per-register pending counter (max in flight = 2**CNT_W-1)
- ZERO_HARDWIRED, 1, when 1 register 0 is never tracked
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  instruction in ID wants to issue
- issue_we  in  1  issuing instruction writes issue_rd
- issue_rd  in  ADDR_W  destination register
- issue_rs1, issue_rs2  in  ADDR_W each  source registers
- issue_ready  out  1  issue accepted this cycle (combinational)
- hazard  out  1  rs1 or rs2 has a pending write (combinational)
- wb_valid  in  NUM_WB  per-port writeback strobe
- wb_rd  in  NUM_WB*ADDR_W  per-port destination; port k at bits [k*ADDR_W +: ADDR_W]
- busy  out  NUM_REGS  registered; bit i = count[i] != 0
- wb_onehot  out  NUM_REGS  registered OR of the decoded one-hots of the valid wb ports
- underflow  out  1  registered one-cycle pulse: writeback to a register with count 0

## Operation
- Decode: onehot(r) = 1 << r. When ZERO_HARDWIRED=1, register 0 decodes to all-zero.
- hazard = (count[issue_rs1] != 0) | (count[issue_rs2] != 0), after masking register 0.
- issue_ready = issue_valid & !hazard & !(issue_we & count[issue_rd] == max).
  - A saturated destination stalls the instruction (WAW depth limit).
- Issue fires when issue_ready=1 and issue_we=1: inc[issue_rd] = 1.
- dec[i] = number of wb ports with wb_valid[k]=1 and wb_rd[k]==i (0..NUM_WB).
- Next count[i] = count[i] + inc[i] - dec[i], computed at CNT_W+2 bits.
  - If the result is negative, the count is clamped to 0 and underflow is asserted next cycle.
  - Saturation is impossible because of the issue_ready gating.
- Register 0 count is held at 0 when ZERO_HARDWIRED=1. Writebacks to register 0 never raise underflow in that case.
- wb_onehot next = OR over k of (wb_valid[k] ? onehot(wb_rd[k]) : 0).

## Timing
- Reset values: all counts 0, busy=0, wb_onehot=0, underflow=0.
  - issue_ready follows its inputs combinationally, so it is 1 if issue_valid=1 after reset.
- Issue at edge N: busy[rd] reads 1 from cycle N+1. A dependent instruction sees hazard=1 in cycle N+1.
- Writeback at edge N: count drops at N+1. wb_onehot reflects the edge-N strobes during cycle N+1 (1-cycle latency).
- Simultaneous issue and writeback to the same register: net change is 0. busy stays 1 if the count was 1.
- Two wb ports hitting the same register in the same cycle: decrement by 2, clamped at 0 with underflow if it goes below.
- Reset mid-operation: all pending counts are discarded in the same edge. Writebacks in the reset cycle are ignored.
- No handshake on the wb side: every strobe is consumed in its own cycle.

## Configuration
- SCOREBOARD_BYPASS_EN defined:
  - hazard and issue_ready use count minus this cycle's dec, so a writeback in cycle N releases a dependent issue in cycle N.
  - This matches the register file's write-before-read bypass.
- Not defined: hazard uses the registered count only. The dependent instruction issues one cycle after the writeback.
- busy, wb_onehot and underflow are identical in both builds.

## Test plan
- Reset, then issue rd=5 (issue_we=1), next cycle rs1=5 -> busy[5]=1 and hazard=1 in cycle 1. With wb_valid[0]=1, wb_rd=5 in cycle 2: without bypass hazard drops in cycle 3; with SCOREBOARD_BYPASS_EN it drops in cycle 2.
- Issue rd=0, and writeback to register 0 -> busy=0, underflow stays 0, wb_onehot=0.
- Issue rd=7 three times (CNT_W=2), then a fourth issue to rd=7 -> issue_ready=0. Stays 0 until a writeback to 7 lowers the count to 2.
- In one cycle, issue rd=9 and writeback rd=9 on port 1 with count 1 -> count stays 1, busy[9]=1, wb_onehot[9]=1 next cycle.
- Both wb ports with rd=3 and count[3]=1 -> count 0 and underflow pulses exactly one cycle. Then assert rst with counts on registers 2 and 4 -> busy=0 the next cycle.
